oser4_nibble_feeder: RTL

//  - Upstream stage of an OSER4 serializer. Runs in the PCLK domain and turns a byte stream
//    (valid/ready) into one 4-bit word per clock for OSER4 D0..D3.
//  - Each byte becomes two nibbles, low nibble first; bit0 of each nibble maps to D0.
//  - Frames each burst with a sync preamble and drives an idle pattern when it has no data.
//  - Also drives OSER4 TX0/TX1 for an optional tristate-on-idle mode.

---
 rtl/oser4_feed_pkg.sv | 22 ++
 rtl/oser4_feed_fifo.sv | 61 ++++++
 rtl/oser4_nibble_feeder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/oser4_feed_pkg.sv
// rtl/oser4_feed_pkg.sv - shared state type and nibble constants for the OSER4 nibble feeder
package oser4_feed_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [NIBBLE_W-1:0] TRAIN_PAT0 = 4'b0101;
  localparam logic [NIBBLE_W-1:0] TRAIN_PAT1 = 4'b1010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRAIN,
    ST_SYNC,
    ST_LO,
    ST_HI
  } feed_state_e;

  // Training phase 0 always opens a burst, so the receiver sees the same alignment each time.
  function automatic logic [NIBBLE_W-1:0] train_nibble(input logic phase);
    return phase ? TRAIN_PAT1 : TRAIN_PAT0;
  endfunction

endpackage

// File: rtl/oser4_feed_fifo.sv
// rtl/oser4_feed_fifo.sv - synchronous byte FIFO with async reset, power-of-two depth
module oser4_feed_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/oser4_nibble_feeder.sv
// rtl/oser4_nibble_feeder.sv - byte stream to OSER4 nibble feeder with sync preamble and idle fill
// Build option OSER4_FEED_TRAIN_EN prepends an alternating training pattern to every burst.
module oser4_nibble_feeder
  import oser4_feed_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] IDLE_PAT   = 4'b1010,
  parameter logic [3:0] SYNC_PAT   = 4'b1100,
  parameter int         SYNC_LEN   = 2,
  parameter int         TRAIN_LEN  = 8,
  parameter bit         TRI_IDLE   = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [3:0]  d_o,
  output logic [1:0]  tx_o,
  output logic        busy_o,
  output logic [15:0] bytes_sent_o
);

`ifdef OSER4_FEED_TRAIN_EN
  localparam int CNT_W = 8;
`else
  localparam int CNT_W = 4;
`endif
  localparam int         FCW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] TX_IDLE = TRI_IDLE ? 2'b11 : 2'b00;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("oser4_nibble_feeder: FIFO_DEPTH must be a power of two >= 2");
  end
  if (SYNC_LEN < 1 || SYNC_LEN > 15 || TRAIN_LEN < 1 || TRAIN_LEN > 255) begin : g_bad_len
    $error("oser4_nibble_feeder: SYNC_LEN or TRAIN_LEN out of range");
  end

  feed_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic [3:0]       d_q, d_d;
  logic [1:0]       tx_q, tx_d;
  logic [15:0]      sent_q;
  logic             pop;

  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   unused_fifo_count;

  oser4_feed_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (s_valid_i),
    .wdata_i (s_data_i),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_fifo_count)
  );

  assign s_ready_o    = !fifo_full;
  assign d_o          = d_q;
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign bytes_sent_o = sent_q;

  // Output registers load from the next state, so d_o lines up with the state it belongs to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    pop     = 1'b0;
    d_d     = IDLE_PAT;
    tx_d    = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (en_i && !fifo_empty) begin
`ifdef OSER4_FEED_TRAIN_EN
          state_d = ST_TRAIN;
`else
          state_d = ST_SYNC;
`endif
          cnt_d = '0;
        end
      end
`ifdef OSER4_FEED_TRAIN_EN
      ST_TRAIN: begin
        if (cnt_q == CNT_W'(TRAIN_LEN - 1)) begin
          state_d = ST_SYNC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      ST_SYNC: begin
        if (cnt_q == CNT_W'(SYNC_LEN - 1)) begin
          pop     = 1'b1;
          byte_d  = fifo_rdata;
          state_d = ST_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LO: state_d = ST_HI;
      ST_HI: begin
        // Back-to-back bytes continue without a fresh preamble.
        if (en_i && !fifo_empty) begin
          pop     = 1'b1;
          byte_d  = fifo_rdata;
          state_d = ST_LO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_IDLE: begin
        d_d  = IDLE_PAT;
        tx_d = TX_IDLE;
      end
`ifdef OSER4_FEED_TRAIN_EN
      ST_TRAIN: d_d = train_nibble(cnt_d[0]);
`endif
      ST_SYNC: d_d = SYNC_PAT;
      ST_LO:   d_d = byte_d[3:0];
      ST_HI:   d_d = byte_d[7:4];
      default: d_d = IDLE_PAT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
      d_q     <= IDLE_PAT;
      tx_q    <= TX_IDLE;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      d_q     <= d_d;
      tx_q    <= tx_d;
      if (state_q == ST_HI) begin
        sent_q <= sent_q + 16'd1;
      end
    end
  end

endmodule
